// File: rtl/branch_target_table.sv
// Label-pointer to PC-target lookup table: target = entry + segment base, entries loaded at run time.
// Lookup latency is one cycle. The table clears itself for DEPTH cycles after reset or clr.
// Backpressure: wr_ready is low while the table is clearing, and the loader holds wr_valid until it is accepted.
module branch_target_table #(
    parameter int                     ADDR_W     = 5,
    parameter int                     TARGET_W   = 12,
    parameter logic [TARGET_W-1:0]    RESET_BASE = '0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                clr,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [TARGET_W-1:0] wr_target,
    input  logic                base_wr,
    input  logic [TARGET_W-1:0] base_in,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [TARGET_W-1:0] Target,
    output logic                rd_valid,
    output logic                rd_hit,
    output logic                init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [TARGET_W-1:0]   base_q, base_d;
    logic [TARGET_W-1:0]   target_q, target_d;
    logic                  rd_valid_q;
    logic                  rd_hit_q, rd_hit_d;
    logic [TARGET_W-1:0]   rd_sum;

    logic [TARGET_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]      vld_q;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [TARGET_W-1:0]   mem_wdat;
    logic                  mem_wvld;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            base_q     <= RESET_BASE;
            target_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                target_q <= target_d;
                rd_hit_q <= rd_hit_d;
            end
        end
    end

    // A single write port serves both the clearing sweep and the loader.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdat  = wr_target;
        mem_wvld  = 1'b1;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdat  = '0;
                mem_wvld  = 1'b0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
                if (base_wr) begin
                    base_d = base_in;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    base_d  = RESET_BASE;
                end else begin
                    if (base_wr) begin
                        base_d = base_in;
                    end
                    mem_we = wr_valid;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Read sees pre-edge entry, valid bit and base, giving read-before-write.
    always_comb begin
        rd_hit_d = (state_q == ST_READY) && vld_q[rd_addr];
        rd_sum   = mem_q[rd_addr] + base_q;
        target_d = rd_hit_d ? rd_sum : '0;
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
            vld_q[mem_waddr] <= mem_wvld;
        end
    end

    assign wr_ready  = (state_q == ST_READY);
    assign init_done = (state_q == ST_READY);
    assign Target    = target_q;
    assign rd_valid  = rd_valid_q;
    assign rd_hit    = rd_hit_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table: vector table in READY plus clr, INIT-read and mid-INIT reset sequences.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_branch_target_table;

    localparam int ADDR_W   = 5;
    localparam int TARGET_W = 12;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                Clk;
    logic                Reset_n;
    logic                clr;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [TARGET_W-1:0] wr_target;
    logic                base_wr;
    logic [TARGET_W-1:0] base_in;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [TARGET_W-1:0] Target;
    logic                rd_valid;
    logic                rd_hit;
    logic                init_done;

    int n_chk;
    int n_fail;

    branch_target_table #(
        .ADDR_W    (ADDR_W),
        .TARGET_W  (TARGET_W),
        .RESET_BASE(12'd0)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_target (wr_target),
        .base_wr   (base_wr),
        .base_in   (base_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .Target    (Target),
        .rd_valid  (rd_valid),
        .rd_hit    (rd_hit),
        .init_done (init_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string               name;
        logic                wr_valid;
        logic [ADDR_W-1:0]   wr_addr;
        logic [TARGET_W-1:0] wr_target;
        logic                base_wr;
        logic [TARGET_W-1:0] base_in;
        logic                rd_en;
        logic [ADDR_W-1:0]   rd_addr;
        logic                exp_valid;
        logic                exp_hit;
        logic [TARGET_W-1:0] exp_target;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_target = '0;
        base_wr = 1'b0; base_in = '0; rd_en = 1'b0; rd_addr = '0;
    endtask

    // Runs DEPTH cycles of INIT, optionally reading one address on cycle rd_at.
    task automatic run_init(input string tag, input int rd_at, input logic [ADDR_W-1:0] addr);
        for (int i = 1; i <= DEPTH; i++) begin
            rd_en   = (i == rd_at);
            rd_addr = addr;
            tick();
            if (i == rd_at) begin
                chk({tag, "_init_rd_valid"}, rd_valid, 1);
                chk({tag, "_init_rd_hit"}, rd_hit, 0);
                chk({tag, "_init_target"}, Target, 0);
            end
            if (i == DEPTH - 1) begin
                chk({tag, "_init_done_early"}, init_done, 0);
                chk({tag, "_wr_ready_early"}, wr_ready, 0);
            end
            if (i == DEPTH) begin
                chk({tag, "_init_done"}, init_done, 1);
                chk({tag, "_wr_ready"}, wr_ready, 1);
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //          name          wv addr tgt    bw base   re raddr  ev eh etgt
        vecs[0]  = '{"wr1_base",  1, 1,  4,     1, 150,   0, 0,     0, 0, 0};
        vecs[1]  = '{"rd1_hit",   0, 0,  0,     0, 0,     1, 1,     1, 1, 154};
        vecs[2]  = '{"rd7_miss",  0, 0,  0,     0, 0,     1, 7,     1, 0, 0};
        vecs[3]  = '{"wr2_hold",  1, 2,  4000,  0, 0,     0, 0,     0, 0, 0};
        vecs[4]  = '{"rd2_wrap",  0, 0,  0,     0, 0,     1, 2,     1, 1, 54};
        vecs[5]  = '{"wr5_hold",  1, 5,  10,    1, 0,     0, 0,     0, 1, 54};
        vecs[6]  = '{"rbw5_old",  1, 5,  20,    0, 0,     1, 5,     1, 1, 10};
        vecs[7]  = '{"rd5_new",   0, 0,  0,     0, 0,     1, 5,     1, 1, 20};
        vecs[8]  = '{"base_old",  0, 0,  0,     1, 100,   1, 5,     1, 1, 20};
        vecs[9]  = '{"base_new",  0, 0,  0,     0, 0,     1, 5,     1, 1, 120};
        vecs[10] = '{"rbw31_miss",1, 31, 4095,  0, 0,     1, 31,    1, 0, 0};
        vecs[11] = '{"rd31_wrap", 0, 0,  0,     0, 0,     1, 31,    1, 1, 99};

        idle_inputs();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        tick();
        tick();
        chk("rst_target", Target, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_hit", rd_hit, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_init_done", init_done, 0);
        Reset_n = 1'b1;
        run_init("boot", 5, 5'd3);

        foreach (vecs[k]) begin
            wr_valid  = vecs[k].wr_valid;
            wr_addr   = vecs[k].wr_addr;
            wr_target = vecs[k].wr_target;
            base_wr   = vecs[k].base_wr;
            base_in   = vecs[k].base_in;
            rd_en     = vecs[k].rd_en;
            rd_addr   = vecs[k].rd_addr;
            tick();
            chk({vecs[k].name, "_valid"}, rd_valid, vecs[k].exp_valid);
            chk({vecs[k].name, "_hit"}, rd_hit, vecs[k].exp_hit);
            chk({vecs[k].name, "_target"}, Target, vecs[k].exp_target);
        end
        idle_inputs();

        // clr with a write (dropped) and a read of addr 1 (pre-clear contents, base 100).
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 5'd9; wr_target = 12'd77;
        rd_en = 1'b1; rd_addr = 5'd1;
        tick();
        chk("clr_rd_target", Target, 104);
        chk("clr_rd_hit", rd_hit, 1);
        chk("clr_init_done", init_done, 0);
        clr = 1'b0;
        wr_addr = 5'd6; wr_target = 12'd300;
        run_init("clr", 3, 5'd1);
        tick();
        wr_valid = 1'b0;
        rd_en = 1'b1; rd_addr = 5'd1;
        tick();
        chk("post_clr_rd1_hit", rd_hit, 0);
        chk("post_clr_rd1_target", Target, 0);
        rd_addr = 5'd6;
        tick();
        chk("held_wr_hit", rd_hit, 1);
        chk("held_wr_base_reset", Target, 300);
        rd_addr = 5'd9;
        tick();
        chk("dropped_wr_hit", rd_hit, 0);

        // clr again with a read of addr 6 so Target is non-zero going into reset.
        clr = 1'b1; rd_addr = 5'd6;
        tick();
        clr = 1'b0; rd_en = 1'b0;
        chk("pre_rst_target", Target, 300);
        for (int i = 0; i < 12; i++) tick();
        chk("mid_init_done", init_done, 0);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_target", Target, 0);
        chk("mid_rst_rd_hit", rd_hit, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        tick();
        tick();
        Reset_n = 1'b1;
        run_init("rerst", 0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
Programmable, parametrised successor to the fixed branch-target lookup table. The fetch stage supplies a short label pointer and receives a full-width PC target one cycle later. The target is the stored entry plus a programmable segment base, so one table serves several loaded programs. The entries are written at run time by the program loader through a ready/valid port, and a per-entry valid bit flags unprogrammed labels.

Parameters:
ADDR_W, 5, label pointer width; DEPTH = 2**ADDR_W entries
TARGET_W, 12, width of stored entries, base offset and output target
RESET_BASE, 0, value loaded into the base-offset register on reset and on clr

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
clr  in  1  single-cycle pulse; invalidates all entries and restores base to RESET_BASE
wr_valid  in  1  loader write request
wr_ready  out  1  table accepts a write this cycle
wr_addr  in  ADDR_W  entry to write
wr_target  in  TARGET_W  value to store
base_wr  in  1  load base-offset register
base_in  in  TARGET_W  new base offset
rd_en  in  1  lookup request
rd_addr  in  ADDR_W  label pointer
Target  out  TARGET_W  registered lookup result
rd_valid  out  1  Target/rd_hit are valid this cycle (one-cycle pulse per rd_en)
rd_hit  out  1  looked-up entry was programmed
init_done  out  1  table is in READY

Behaviour:
- Reset (async, Reset_n=0): state=INIT, init counter=0, base=RESET_BASE. Target=0, rd_valid=0, rd_hit=0, wr_ready=0, init_done=0. All outputs take these values immediately, including mid-operation.
- FSM has two states: INIT and READY.
- INIT: clears the valid bit of entry[counter] and the entry data to 0, one entry per cycle. The counter runs 0..DEPTH-1. After clearing entry DEPTH-1, the next state is READY. INIT therefore lasts exactly DEPTH cycles.
- READY: wr_ready=1, init_done=1. A clr pulse returns the FSM to INIT with counter=0 and base=RESET_BASE. clr is ignored while already in INIT.
- Write: accepted when wr_valid && wr_ready. On that edge, entry[wr_addr]=wr_target and valid[wr_addr]=1. Writes presented in INIT are not accepted; the loader holds wr_valid until wr_ready is high.
- Read: rd_en at cycle N gives rd_valid=1 at cycle N+1. The result is taken from state as of cycle N:
  - on a hit: Target=(entry + base) mod 2**TARGET_W (wrap, no saturation) and rd_hit=1;
  - on a miss: Target=0 and rd_hit=0.
- Read in INIT: rd_valid=1, rd_hit=0, Target=0.
- rd_en=0: rd_valid=0, and Target/rd_hit hold their previous values.
- Same-cycle read and write to the same address: the read returns the pre-write contents (read-before-write). The new value is visible from the following rd_en.
- Same-cycle base_wr and rd_en: the read uses the old base. base_wr is honoured in both states, except in the cycle clr is accepted, when clr wins.
- Same-cycle clr and write in READY: clr wins and the write is dropped; wr_ready is already high, so the loader must not rely on that write.
- Same-cycle clr and rd_en in READY: the read completes against pre-clear contents.
- Reset asserted mid-INIT: the counter restarts from 0 after deassertion, and the full DEPTH-cycle INIT repeats.

Test Plan:
- Reset deassert, DEPTH=32 -> init_done rises exactly 32 cycles later; rd_en on addr 3 during INIT -> rd_valid=1, rd_hit=0, Target=0.
- After INIT: write addr 1 = 4, base_wr 150, then rd_en addr 1 -> next cycle Target=154, rd_hit=1; rd_en addr 7 (unwritten) -> Target=0, rd_hit=0.
- Wrap: write addr 2 = 4000, base 150, read addr 2 -> Target=54 (4150 mod 4096), rd_hit=1.
- Same cycle: addr 5 holds 10, write addr 5 = 20 with rd_en addr 5 and base 0 -> Target=10; next rd_en addr 5 -> Target=20.
- clr in READY with addr 1 programmed -> init_done low for 32 cycles, base=RESET_BASE; a write held during INIT completes on the first READY cycle; read addr 1 afterwards -> rd_hit=0.
- Reset_n pulsed low at INIT counter=12 -> outputs at reset values immediately; after deassertion init_done rises after a full 32 cycles.
